// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// RF_WPORT_ARB_TRACE_EN widens FIFO entries to carry the instruction PC.
package rf_wport_arbiter_pkg;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_FORCE_MD = 1'b1
    } rf_wport_state_e;

    localparam int DEFAULT_FIFO_DEPTH   = 2;
    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_CNT_W        = 3;

`ifdef RF_WPORT_ARB_TRACE_EN
    localparam int MD_FIFO_ENTRY_WD = 69;
`else
    localparam int MD_FIFO_ENTRY_WD = 37;
`endif

endpackage

// File: rtl/rf_wport_arbiter_md_result_fifo.sv
// md_result_fifo: small synchronous FIFO holding mul/div results awaiting
// a write-port slot. Caller guarantees no push when full, no pop when empty.
module md_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single RF write port between WB (priority) and buffered
// mul/div results, with starvation forcing. Trace ports: RF_WPORT_ARB_TRACE_EN.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        wb_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_waddr,
    input  logic [31:0] md_wdata,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef RF_WPORT_ARB_TRACE_EN
    input  logic [31:0] wb_pc,
    input  logic [31:0] md_pc,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
`endif
    output logic        md_pending
);

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    rf_wport_state_e r_state;
    rf_wport_state_e w_state_next;
    logic [CNT_W-1:0] r_starve_cnt;

    logic w_wb_grant;
    logic w_md_grant;
    logic w_push;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_starve_hit;
    logic [FIFO_CNT_W-1:0]       w_fifo_count;
    logic [MD_FIFO_ENTRY_WD-1:0] w_push_entry;
    logic [MD_FIFO_ENTRY_WD-1:0] w_head;
    logic        w_sel_valid;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

`ifdef RF_WPORT_ARB_TRACE_EN
    assign w_push_entry = {md_pc, md_waddr, md_wdata};
`else
    assign w_push_entry = {md_waddr, md_wdata};
`endif

    assign w_push       = md_valid & ~w_fifo_full;
    assign w_wb_grant   = wb_valid & wb_we & (r_state == ST_NORMAL);
    assign w_md_grant   = ~w_wb_grant & ~w_fifo_empty;
    assign w_starve_hit = w_wb_grant & ~w_fifo_empty &
                          (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1));

    md_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MD_FIFO_ENTRY_WD)
    ) u_md_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_md_grant),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_NORMAL;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_NORMAL:   if (w_starve_hit) w_state_next = ST_FORCE_MD;
            ST_FORCE_MD: w_state_next = ST_NORMAL;
        endcase
    end

    // Depends on state only, keeping md_valid out of WB's allow-in path.
    always_comb begin
        wb_ready = (r_state == ST_NORMAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if ((r_state == ST_FORCE_MD) || w_fifo_empty || w_md_grant) begin
            r_starve_cnt <= '0;
        end else if (w_wb_grant) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        if (w_wb_grant) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = wb_waddr;
            w_sel_data  = wb_wdata;
        end else if (w_md_grant) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = w_head[36:32];
            w_sel_data  = w_head[31:0];
        end
    end

    // r0 writes retire but leave the bus fully quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (w_sel_valid && (w_sel_addr != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= w_sel_addr;
            rf_wdata <= w_sel_data;
        end else begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end
    end

`ifdef RF_WPORT_ARB_TRACE_EN
    logic [31:0] r_debug_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_debug_pc <= '0;
        end else if (w_md_grant) begin
            r_debug_pc <= w_head[68:37];
        end else if (wb_valid & wb_ready) begin
            r_debug_pc <= wb_pc;
        end
    end

    assign debug_wb_pc       = r_debug_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

    assign md_ready   = ~w_fifo_full;
    assign md_pending = (w_fifo_count != '0);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_rf_wport_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_ready;
    logic        md_valid;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        md_pending;
`ifdef RF_WPORT_ARB_TRACE_EN
    logic [31:0] wb_pc, md_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_forced;
    int          m_starve;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    rf_wport_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_ready   (wb_ready),
        .md_valid   (md_valid),
        .md_waddr   (md_waddr),
        .md_wdata   (md_wdata),
        .md_ready   (md_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
`ifdef RF_WPORT_ARB_TRACE_EN
        .wb_pc             (wb_pc),
        .md_pc             (md_pc),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
        .md_pending (md_pending)
    );

    task automatic clear_inputs();
        wb_valid = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        md_valid = 0; md_waddr = 0; md_wdata = 0;
`ifdef RF_WPORT_ARB_TRACE_EN
        wb_pc = 0; md_pc = 0;
`endif
    endtask

    task automatic model_clear();
        q.delete();
        m_forced = 0; m_starve = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Advance one clock: model predicts the write for this edge from the
    // arbitration rules, then the DUT is sampled 1ns after the edge.
    task automatic step();
        bit   wbwin, hdwin, pushed;
        ent_t sel, nw;
        wbwin  = wb_valid && wb_we && !m_forced;
        hdwin  = !wbwin && (q.size() > 0);
        pushed = md_valid && (q.size() < DEPTH);
        sel = '0;
        if (wbwin) begin sel.a = wb_waddr; sel.d = wb_wdata; end
        else if (hdwin) sel = q[0];
        if ((wbwin || hdwin) && sel.a != 5'd0) begin
            exp_we = 1; exp_addr = sel.a; exp_data = sel.d;
        end else begin
            exp_we = 0; exp_addr = 0; exp_data = 0;
        end
        if (m_forced) begin
            m_forced = 0; m_starve = 0;
        end else if (q.size() == 0 || hdwin) begin
            m_starve = 0;
        end else if (wbwin) begin
            if (m_starve == LIMIT - 1) m_forced = 1;
            m_starve++;
        end
        if (hdwin) void'(q.pop_front());
        if (pushed) begin nw.a = md_waddr; nw.d = md_wdata; q.push_back(nw); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin failures++; $display("FAIL reset_rf: got %0b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL reset_md_ready: got %b want 1", md_ready); end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL reset_md_pending: got %b want 0", md_pending); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
        reset = 1'b0;
        model_clear();
        $display("reset: rf_we=%b md_ready=%b wb_ready=%b", rf_we, md_ready, wb_ready);
    endtask

    task automatic test_wb_only();
        do_reset();
        wb_valid = 1; wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234;
        step();
        clear_inputs();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin failures++; $display("FAIL wb_only_write: got %b/%0d/%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL wb_only_ready: got %b want 1", wb_ready); end
        $display("wb_only: rf_we=%b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
    endtask

    task automatic test_md_only();
        do_reset();
        md_valid = 1; md_waddr = 7; md_wdata = 32'hDEADBEEF;
        step();
        clear_inputs();
        checks++; if (md_pending !== 1'b1) begin failures++; $display("FAIL md_only_pending1: got %b want 1", md_pending); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL md_only_no_bypass: got rf_we=%b want 0", rf_we); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin failures++; $display("FAIL md_only_write: got %b/%0d/%h want 1/7/deadbeef", rf_we, rf_waddr, rf_wdata); end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL md_only_pending0: got %b want 0", md_pending); end
        $display("md_only: rf_we=%b addr=%0d data=%h", rf_we, rf_waddr, rf_wdata);
    endtask

    task automatic test_starvation();
        do_reset();
        md_valid = 1; md_waddr = 9; md_wdata = 32'h5555_0009;
        wb_valid = 1; wb_we = 1; wb_waddr = 1; wb_wdata = 32'd100;
        step();
        md_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            wb_waddr = 5'(2 + i); wb_wdata = 32'(200 + i);
            checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL starve_wb_ready_%0d: got %b want 1", i, wb_ready); end
            step();
            checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'(2 + i)}) begin failures++; $display("FAIL starve_wb_win_%0d: got %b/%0d want 1/%0d", i, rf_we, rf_waddr, 2 + i); end
        end
        checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL starve_force_ready: got %b want 0", wb_ready); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h5555_0009}) begin failures++; $display("FAIL starve_head_write: got %b/%0d/%h want 1/9/55550009", rf_we, rf_waddr, rf_wdata); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL starve_resume_ready: got %b want 1", wb_ready); end
        step();
        checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'(2 + LIMIT - 1)}) begin failures++; $display("FAIL starve_wb_resume: got %b/%0d want 1/%0d", rf_we, rf_waddr, 2 + LIMIT - 1); end
        clear_inputs();
        $display("starvation: forced slot observed, wb resumed addr=%0d", rf_waddr);
    endtask

    task automatic test_full_fifo();
        bit accepted = 0;
        bit seen_c   = 0;
        do_reset();
        wb_valid = 1; wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44;
        md_valid = 1; md_waddr = 10; md_wdata = 32'hA;
        step();
        md_waddr = 11; md_wdata = 32'hB;
        step();
        md_valid = 0;
        checks++; if (md_ready !== 1'b0) begin failures++; $display("FAIL full_md_ready: got %b want 0", md_ready); end
        checks++; if (md_pending !== 1'b1) begin failures++; $display("FAIL full_md_pending: got %b want 1", md_pending); end
        md_valid = 1; md_waddr = 12; md_wdata = 32'hC;
        for (int i = 0; i < 12 && !accepted; i++) begin
            checks++; if (md_ready !== 1'(q.size() < DEPTH)) begin failures++; $display("FAIL full_ready_c%0d: got %b want %b", i, md_ready, q.size() < DEPTH); end
            if (md_ready === 1'b1) accepted = 1;
            step();
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_addr, exp_data}) begin failures++; $display("FAIL full_rf_c%0d: got %b/%0d/%h want %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_addr, exp_data); end
        end
        md_valid = 0;
        checks++; if (!accepted) begin failures++; $display("FAIL full_accept_timeout: got accepted=0 want 1"); end
        wb_valid = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rf_we === 1'b1 && rf_waddr === 5'd12 && rf_wdata === 32'hC) seen_c = 1;
        end
        checks++; if (!seen_c) begin failures++; $display("FAIL full_third_written: got seen=0 want 1"); end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL full_drained: got md_pending=%b want 0", md_pending); end
        clear_inputs();
        $display("full_fifo: third accepted=%0d written=%0d", accepted, seen_c);
    endtask

    task automatic test_addr0_nowrite();
        do_reset();
        wb_valid = 1; wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFFFFFF;
        step();
        checks++; if ({rf_we, rf_wdata} !== {1'b0, 32'd0}) begin failures++; $display("FAIL addr0_quiet: got %b/%h want 0/0", rf_we, rf_wdata); end
        wb_waddr = 3; wb_wdata = 32'h33;
        md_valid = 1; md_waddr = 20; md_wdata = 32'hCAFE0020;
        step();
        md_valid = 0;
        wb_we = 0; wb_waddr = 6; wb_wdata = 32'h66;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL nowrite_wb_ready: got %b want 1", wb_ready); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 32'hCAFE0020}) begin failures++; $display("FAIL nowrite_head_slot: got %b/%0d/%h want 1/20/cafe0020", rf_we, rf_waddr, rf_wdata); end
        clear_inputs();
        $display("addr0_nowrite: head written addr=%0d data=%h", rf_waddr, rf_wdata);
    endtask

    task automatic test_async_reset();
        bit reached = 0;
        do_reset();
        wb_valid = 1; wb_we = 1; wb_waddr = 8; wb_wdata = 32'h88;
        md_valid = 1; md_waddr = 13; md_wdata = 32'hD;
        step();
        md_waddr = 14; md_wdata = 32'hE;
        step();
        md_valid = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (m_forced && q.size() == DEPTH) reached = 1;
            else step();
        end
        checks++; if (!reached || wb_ready !== 1'b0) begin failures++; $display("FAIL areset_setup: got reached=%0d wb_ready=%b want 1/0", reached, wb_ready); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL areset_rf_we: got %b want 0", rf_we); end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL areset_md_pending: got %b want 0", md_pending); end
        checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL areset_md_ready: got %b want 1", md_ready); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL areset_wb_ready: got %b want 1", wb_ready); end
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL areset_fifo_discarded: got rf_we=%b want 0", rf_we); end
        $display("async_reset: outputs cleared between edges");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_we    = ($urandom_range(0, 3) != 0);
            wb_waddr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) wb_waddr = 0;
            wb_wdata = $urandom;
            md_valid = ($urandom_range(0, 2) == 0);
            md_waddr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) md_waddr = 0;
            md_wdata = $urandom;
            checks++; if (wb_ready !== 1'(!m_forced)) begin failures++; $display("FAIL rand_wb_ready_%0d: got %b want %b", i, wb_ready, !m_forced); end
            checks++; if (md_ready !== 1'(q.size() < DEPTH)) begin failures++; $display("FAIL rand_md_ready_%0d: got %b want %b", i, md_ready, q.size() < DEPTH); end
            checks++; if (md_pending !== 1'(q.size() > 0)) begin failures++; $display("FAIL rand_md_pending_%0d: got %b want %b", i, md_pending, q.size() > 0); end
            step();
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_addr, exp_data}) begin failures++; $display("FAIL rand_rf_%0d: got %b/%0d/%h want %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_addr, exp_data); end
        end
        clear_inputs();
        $display("random: 400 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_md_only();
        test_starvation();
        test_full_fifo();
        test_addr0_nowrite();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
